// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller.
//   AddrBus/ByteBus/InstBus - bus widths
//   LEN_1/LEN_2/LEN_4       - lsb_len encodings for 1, 2 and 4 byte requests
//   IoAddrHiDefault         - addr[17:16] value of the memory-mapped IO region
//   state_e                 - controller FSM states
package mem_ctrl_pkg;

    localparam int unsigned AddrBus = 32;
    localparam int unsigned ByteBus = 8;
    localparam int unsigned InstBus = 32;

    localparam logic [1:0] LEN_1 = 2'd0;
    localparam logic [1:0] LEN_2 = 2'd1;
    localparam logic [1:0] LEN_4 = 2'd2;

    localparam logic [1:0] IoAddrHiDefault = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StWrite = 2'd3
    } state_e;

    // Encoding 3 is reserved and behaves as a word access.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_1:   n = 3'd1;
            LEN_2:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory-side responder: owns the byte-wide RAM/IO bus and, every cycle, either lends it to
// instruction fetch or moves one byte of a multi-byte LSB load/store.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   if_req_addr / if_rdy / if_byte          - fetch side
//   io_is_writing                           - IO store pending or in flight
//   lsb_valid/we/addr/len/wdata, rob_clear  - LSB request side
//   lsb_done / lsb_rdata                    - LSB completion
//   mem_din/mem_dout/mem_a/mem_wr           - RAM/IO bus
//   io_buffer_full                          - IO write FIFO back-pressure
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0]  IO_ADDR_HI = IoAddrHiDefault,
    parameter int unsigned ADDR_W     = AddrBus
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic [ADDR_W-1:0]  if_req_addr,
    output logic               if_rdy,
    output logic [ByteBus-1:0] if_byte,
    output logic               io_is_writing,
    input  logic               lsb_valid,
    input  logic               lsb_we,
    input  logic [ADDR_W-1:0]  lsb_addr,
    input  logic [1:0]         lsb_len,
    input  logic [InstBus-1:0] lsb_wdata,
    input  logic               rob_clear,
    output logic               lsb_done,
    output logic [InstBus-1:0] lsb_rdata,
    input  logic [ByteBus-1:0] mem_din,
    output logic [ByteBus-1:0] mem_dout,
    output logic [ADDR_W-1:0]  mem_a,
    output logic               mem_wr,
    input  logic               io_buffer_full
);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q;
    logic [2:0]          nbytes_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [InstBus-1:0]  wdata_q;
    logic [InstBus-1:0]  data_q;
    logic                is_io_q;
    logic                io_wr_q;
    logic                done_hold_q;  // forces one fetch-granted IDLE cycle after a done
    logic                rd_pend_q;    // a read address was on the bus last cycle
    logic [1:0]          rd_lane_q;    // byte lane that read belongs to

    logic                accept;
    logic                is_io_req;
    logic                last;
    logic                wr_stall;
    logic                done_int;
    logic [ADDR_W-1:0]   cur_addr;
    logic [InstBus-1:0]  wdata_sh;
    logic [InstBus-1:0]  rdata_mrg;

    assign is_io_req = (lsb_addr[17:16] == IO_ADDR_HI);
    assign accept    = rdy_in && (state_q == StIdle) && lsb_valid && !rob_clear && !done_hold_q;
    assign last      = (cnt_q == nbytes_q - 3'd1);
    assign wr_stall  = is_io_q && io_buffer_full;
    assign cur_addr  = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
    assign wdata_sh  = wdata_q >> {cnt_q[1:0], 3'b000};
    assign done_int  = rdy_in && (((state_q == StDrain) && !rob_clear) ||
                                  ((state_q == StWrite) && !wr_stall && last));

    // State register. Read data is captured on the cycle after its address regardless of
    // rdy_in, since the RAM returns data exactly one cycle after the address.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            is_io_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            done_hold_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_lane_q   <= '0;
        end else begin
            rd_pend_q <= rdy_in && (state_q == StRead);
            rd_lane_q <= cnt_q[1:0];
            if (accept) begin
                data_q <= '0;
            end else if (rd_pend_q) begin
                data_q[{rd_lane_q, 3'b000} +: ByteBus] <= mem_din;
            end
            if (rdy_in) begin
                state_q     <= state_d;
                done_hold_q <= done_int;
                if (accept) begin
                    addr_q   <= lsb_addr;
                    wdata_q  <= lsb_wdata;
                    nbytes_q <= len_to_nbytes(lsb_len);
                    is_io_q  <= is_io_req;
                    io_wr_q  <= lsb_we && is_io_req;
                    cnt_q    <= '0;
                end else begin
                    if ((state_q == StRead) || ((state_q == StWrite) && !wr_stall)) begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                    // IDLE after a store is the trailing io_is_writing cycle.
                    if (state_q == StIdle) begin
                        io_wr_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Next-state logic. Stores are committed, so rob_clear only aborts loads.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = lsb_we ? StWrite : StRead;
                end
            end
            StRead: begin
                if (rob_clear) begin
                    state_d = StIdle;
                end else if (last) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            StWrite: begin
                if (!wr_stall && last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Last load byte arrives during DRAIN, so it is merged straight from mem_din.
    always_comb begin
        rdata_mrg = data_q;
        if (rd_pend_q) begin
            rdata_mrg[{rd_lane_q, 3'b000} +: ByteBus] = mem_din;
        end
    end

    // Outputs.
    always_comb begin
        if_rdy        = 1'b0;
        if_byte       = mem_din;
        io_is_writing = io_wr_q || (accept && lsb_we && is_io_req);
        lsb_done      = done_int;
        lsb_rdata     = rdata_mrg;
        mem_a         = if_req_addr;
        mem_wr        = 1'b0;
        mem_dout      = '0;
        unique case (state_q)
            StIdle:  if_rdy = rdy_in && !accept;
            StRead,
            StDrain: mem_a = cur_addr;
            StWrite: begin
                mem_a    = cur_addr;
                mem_dout = wdata_sh[ByteBus-1:0];
                mem_wr   = rdy_in && !wr_stall;
            end
            default: ;
        endcase
        if (rst_in) begin
            if_rdy        = 1'b0;
            if_byte       = '0;
            io_is_writing = 1'b0;
            lsb_done      = 1'b0;
            lsb_rdata     = '0;
            mem_a         = '0;
            mem_wr        = 1'b0;
            mem_dout      = '0;
        end
    end

endmodule
